// File: rtl/alu_seq.sv
// alu_seq: WIDTH-bit sequential ALU with start/done handshake and registered result/flags.
// Define ALU_SEQ_DIV_EN to build the iterative restoring divider for div/mod.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int OPW = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OPW-1:0]   operation,
  input  logic [WIDTH-1:0] in_bus,
  input  logic [WIDTH-1:0] in_AC,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             carry,
  output logic             mul_ovf,
  output logic             div_zero,
  output logic             zero
);
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0] sum;
  logic is_mul, is_add, is_sub, is_div, is_mod, accept;
  logic [WIDTH-1:0] res;
  logic res_c, res_o, res_dz;
  assign prod = {{WIDTH{1'b0}}, in_AC} * {{WIDTH{1'b0}}, in_bus};
  assign sum = {1'b0, in_AC} + {1'b0, in_bus};
  assign is_mul = operation == OPW'(1);
  assign is_add = operation == OPW'(2);
  assign is_sub = operation == OPW'(3);
  assign is_div = operation == OPW'(4);
  assign is_mod = operation == OPW'(5);
  assign accept = start && !busy;
  assign zero = data_out == '0;
`ifdef ALU_SEQ_DIV_EN
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, DIV} state_t;
  state_t state;
  logic [WIDTH-1:0] dvd, dvs, rem, rem_n;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] sh;
  logic mod_op, ge;
  assign busy = state == DIV;
  // remainder needs one extra bit after the shift so the trial subtract never overflows
  assign sh = {rem, dvd[WIDTH-1]};
  assign ge = sh >= {1'b0, dvs};
  assign rem_n = ge ? WIDTH'(sh - {1'b0, dvs}) : sh[WIDTH-1:0];
`else
  assign busy = 1'b0;
`endif
  always_comb begin
    res = is_mul ? prod[WIDTH-1:0] : is_add ? sum[WIDTH-1:0] : is_sub ? in_AC - in_bus : in_bus;
    res_c = (is_add && sum[WIDTH]) || (is_sub && in_AC < in_bus);
    res_o = is_mul && prod[2*WIDTH-1:WIDTH] != '0;
`ifdef ALU_SEQ_DIV_EN
    res = is_div ? '1 : is_mod ? in_AC : res;
    res_dz = (is_div || is_mod) && in_bus == '0;
`else
    res = (is_div || is_mod) ? '0 : res;
    res_dz = is_div || is_mod;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      done <= 1'b0;
      data_out <= '0;
      carry <= 1'b0;
      mul_ovf <= 1'b0;
      div_zero <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      state <= IDLE;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      cnt <= '0;
      mod_op <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      if (busy) begin
        rem <= rem_n;
        dvd <= {dvd[WIDTH-2:0], ge};
        cnt <= cnt - CW'(1);
        if (cnt == '0) begin
          data_out <= mod_op ? rem_n : {dvd[WIDTH-2:0], ge};
          carry <= 1'b0;
          mul_ovf <= 1'b0;
          div_zero <= 1'b0;
          done <= 1'b1;
          state <= IDLE;
        end
      end else if (accept && (is_div || is_mod) && in_bus != '0) begin
        dvd <= in_AC;
        dvs <= in_bus;
        rem <= '0;
        cnt <= CW'(WIDTH - 1);
        mod_op <= is_mod;
        state <= DIV;
      end else
`endif
      if (accept) begin
        data_out <= res;
        carry <= res_c;
        mul_ovf <= res_o;
        div_zero <= res_dz;
        done <= 1'b1;
      end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: vector table, hand sequences and random ops against a behavioural model of alu_seq.
module tb_alu_seq;
  localparam int W = 16;
`ifdef ALU_SEQ_DIV_EN
  localparam bit DIVEN = 1'b1;
`else
  localparam bit DIVEN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [2:0] operation = '0;
  logic [W-1:0] in_bus = '0, in_AC = '0;
  logic busy, done, carry, mul_ovf, div_zero, zero;
  logic [W-1:0] data_out;
  int checks = 0, errors = 0;

  alu_seq #(.WIDTH(W), .OPW(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .operation(operation), .in_bus(in_bus), .in_AC(in_AC),
    .busy(busy), .done(done), .data_out(data_out), .carry(carry), .mul_ovf(mul_ovf),
    .div_zero(div_zero), .zero(zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [2:0] op;
    logic [W-1:0] a, b, d;
    logic c, o, dz;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [2:0] op, input logic [W-1:0] b);
    return (DIVEN && (op == 3'd4 || op == 3'd5) && b != 0) ? W : 0;
  endfunction

  // plain-arithmetic reference: full-width integers, then truncate
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] d, output logic c, output logic o, output logic dz);
    int unsigned ua = a, ub = b, r;
    d = b; c = 0; o = 0; dz = 0;
    case (op)
      3'd1: begin r = ua * ub; d = r[W-1:0]; o = r > 32'hFFFF; end
      3'd2: begin r = ua + ub; d = r[W-1:0]; c = r > 32'hFFFF; end
      3'd3: begin d = a - b; c = ua < ub; end
      3'd4, 3'd5:
        if (!DIVEN) begin d = 0; dz = 1; end
        else if (ub == 0) begin dz = 1; d = (op == 3'd4) ? 16'hFFFF : a; end
        else begin r = (op == 3'd4) ? ua / ub : ua % ub; d = r[W-1:0]; end
      default: ;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output logic bsy);
    @(negedge clk);
    start = 1; operation = op; in_AC = a; in_bus = b;
    @(posedge clk); #1;
    start = 0; bsy = busy; lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_op(input string name, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] d, input logic c, input logic o, input logic dz);
    int lat, el;
    logic bsy;
    el = exp_lat(op, b);
    do_op(op, a, b, lat, bsy);
    chk({name, " latency"}, lat, el);
    chk({name, " busy"}, bsy, el > 0);
    chk({name, " data_out"}, data_out, d);
    chk({name, " carry"}, carry, c);
    chk({name, " mul_ovf"}, mul_ovf, o);
    chk({name, " div_zero"}, div_zero, dz);
    chk({name, " zero"}, zero, d == 0);
  endtask

  initial begin
    int lat, n;
    logic bsy, c, o, dz;
    logic [2:0] op;
    logic [W-1:0] a, b, d;
    tbl = '{
      '{3'd2, 16'hFFFF, 16'h0002, 16'h0001, 1'b1, 1'b0, 1'b0},
      '{3'd3, 16'd3, 16'd5, 16'hFFFE, 1'b1, 1'b0, 1'b0},
      '{3'd1, 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b1, 1'b0},
      '{3'd1, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 1'b0, 1'b0},
      '{3'd2, 16'd1, 16'd2, 16'd3, 1'b0, 1'b0, 1'b0},
      '{3'd3, 16'd5, 16'd3, 16'd2, 1'b0, 1'b0, 1'b0},
      '{3'd3, 16'd5, 16'd5, 16'd0, 1'b0, 1'b0, 1'b0},
      '{3'd0, 16'h5555, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0},
      '{3'd7, 16'h0001, 16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b0},
      '{3'd6, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0},
      '{3'd4, 16'd55, 16'd0, DIVEN ? 16'hFFFF : 16'h0000, 1'b0, 1'b0, 1'b1},
      '{3'd5, 16'd55, 16'd0, DIVEN ? 16'd55 : 16'd0, 1'b0, 1'b0, 1'b1},
      '{3'd4, 16'd1000, 16'd7, DIVEN ? 16'd142 : 16'd0, 1'b0, 1'b0, !DIVEN},
      '{3'd5, 16'd1000, 16'd7, DIVEN ? 16'd6 : 16'd0, 1'b0, 1'b0, !DIVEN}
    };
    #12;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst data_out", data_out, 0);
    chk("rst carry", carry, 0);
    chk("rst mul_ovf", mul_ovf, 0);
    chk("rst div_zero", div_zero, 0);
    chk("rst zero", zero, 1);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 14; i++)
      check_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].c, tbl[i].o, tbl[i].dz);

    // back-to-back single-cycle ops, one done per cycle
    @(negedge clk);
    start = 1; operation = 3'd2; in_AC = 16'd1; in_bus = 16'd1;
    @(posedge clk); #1;
    chk("b2b0 done", done, 1);
    chk("b2b0 data_out", data_out, 16'd2);
    operation = 3'd3; in_AC = 16'd2; in_bus = 16'd5;
    @(posedge clk); #1;
    chk("b2b1 done", done, 1);
    chk("b2b1 data_out", data_out, 16'hFFFD);
    chk("b2b1 carry", carry, 1);
    operation = 3'd7; in_bus = 16'd7;
    @(posedge clk); #1;
    start = 0;
    chk("b2b2 done", done, 1);
    chk("b2b2 data_out", data_out, 16'd7);
    chk("b2b2 carry", carry, 0);
    @(posedge clk); #1;
    chk("b2b idle done", done, 0);
    chk("b2b hold data_out", data_out, 16'd7);

`ifdef ALU_SEQ_DIV_EN
    // start mid-division is dropped
    @(negedge clk);
    start = 1; operation = 3'd4; in_AC = 16'd1000; in_bus = 16'd7;
    @(posedge clk); #1;
    start = 0; lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 5) begin start = 1; operation = 3'd2; in_AC = 16'd1; in_bus = 16'd1; end
      if (lat == 6) start = 0;
    end
    chk("middiv latency", lat, W);
    chk("middiv data_out", data_out, 16'd142);
    @(posedge clk); #1;
    chk("middiv no extra done", done, 0);
    chk("middiv hold data_out", data_out, 16'd142);

    // start in the done cycle of a division is accepted
    do_op(3'd4, 16'd100, 16'd10, lat, bsy);
    chk("donecyc div latency", lat, W);
    chk("donecyc div data_out", data_out, 16'd10);
    start = 1; operation = 3'd0; in_bus = 16'h0055;
    @(posedge clk); #1;
    start = 0;
    chk("donecyc pass done", done, 1);
    chk("donecyc pass data_out", data_out, 16'h0055);

    // reset at cycle 8 of a division aborts it
    @(negedge clk);
    start = 1; operation = 3'd4; in_AC = 16'd1000; in_bus = 16'd7;
    @(posedge clk); #1;
    start = 0;
    repeat (7) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort data_out", data_out, 0);
    @(negedge clk);
    rst_n = 1;
    n = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    chk("abort no done", n, 0);
    check_op("after abort pass", 3'd0, 16'd0, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      a = 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      if ($urandom_range(0, 1) == 1) a = 16'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) b = 16'($urandom_range(0, 255));
      model(op, a, b, d, c, o, dz);
      check_op($sformatf("rnd%0d op%0d", i, op), op, a, b, d, c, o, dz);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
